// File: rtl/m31_pkg.sv
// Shared definitions for Mersenne-field (p = 2^w - 1) arithmetic and the
// circulant multiplier FSM encoding.
package m31_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } m31_state_e;

  localparam int unsigned M31_MAX_W = 32;

  // Two hi+lo folds bring any 2w-bit product to at most p; p itself maps to 0.
  function automatic logic [31:0] m31_reduce(input logic [63:0] x, input int unsigned w);
    logic [63:0] mask;
    logic [63:0] s1;
    logic [63:0] s2;
    mask = (64'd1 << w) - 64'd1;
    s1   = (x >> w) + (x & mask);
    s2   = (s1 >> w) + (s1 & mask);
    if (s2 == mask) s2 = '0;
    return 32'(s2);
  endfunction

  function automatic logic [31:0] m31_mod_add(input logic [31:0] a, input logic [31:0] b,
                                              input int unsigned w);
    logic [32:0] p;
    logic [32:0] s;
    p = (33'd1 << w) - 33'd1;
    s = {1'b0, a} + {1'b0, b};
    if (s >= p) s = s - p;
    return 32'(s);
  endfunction

endpackage

// File: rtl/m31_mac.sv
// Combinational multiply-accumulate over the Mersenne field: (acc + a*b) mod p.
module m31_mac
  import m31_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 31
) (
  input  logic [WORD_WIDTH-1:0] acc,
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [WORD_WIDTH-1:0] b,
  output logic [WORD_WIDTH-1:0] sum
);

  logic [63:0] prod;

  // acc is always canonical; a and b may equal p and still reduce correctly.
  always_comb begin
    prod = 64'(a) * 64'(b);
    sum  = WORD_WIDTH'(m31_mod_add(32'(acc), m31_reduce(prod, WORD_WIDTH), WORD_WIDTH));
  end

endmodule

// File: rtl/circ_mtx_vec_mul_seq.sv
// Lane-parallel circulant matrix-vector multiplier over p = 2^WORD_WIDTH - 1,
// LANES rows per group, one column per cycle, with valid/ready on both sides.
module circ_mtx_vec_mul_seq
  import m31_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 31,
  parameter int unsigned MTX_SIZE   = 16,
  parameter int unsigned LANES      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] mtx_row [MTX_SIZE],
  input  logic [WORD_WIDTH-1:0] vec     [MTX_SIZE],
  input  logic                  shift_left,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WORD_WIDTH-1:0] result  [MTX_SIZE],
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  busy
);

  localparam int unsigned NGRP = MTX_SIZE / LANES;
  localparam int unsigned CW   = (MTX_SIZE > 1) ? $clog2(MTX_SIZE) : 1;
  localparam int unsigned GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(MTX_SIZE - 1);
  localparam logic [GW-1:0] GRP_LAST = GW'(NGRP - 1);

  if ((MTX_SIZE % LANES) != 0) begin : g_bad_lanes
    $error("LANES must divide MTX_SIZE");
  end
  if (WORD_WIDTH < 2 || WORD_WIDTH > M31_MAX_W) begin : g_bad_width
    $error("WORD_WIDTH out of supported range");
  end

  m31_state_e            state_q, state_d;
  logic [CW-1:0]         col_q, col_d;
  logic [GW-1:0]         grp_q, grp_d;
  logic                  sl_q, sl_d;
  logic [WORD_WIDTH-1:0] mtx_q [MTX_SIZE];
  logic [WORD_WIDTH-1:0] mtx_d [MTX_SIZE];
  logic [WORD_WIDTH-1:0] vec_q [MTX_SIZE];
  logic [WORD_WIDTH-1:0] vec_d [MTX_SIZE];
  logic [WORD_WIDTH-1:0] mac_sum [LANES];
  logic                  accept;
  logic                  run;
  logic                  last_col;

  assign in_ready     = (state_q == ST_IDLE);
  assign busy         = (state_q == ST_RUN);
  assign result_valid = (state_q == ST_DONE);
  assign accept       = in_ready && in_valid;
  assign run          = busy;
  assign last_col     = (col_q == COL_LAST);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    grp_d   = grp_q;
    sl_d    = sl_q;
    mtx_d   = mtx_q;
    vec_d   = vec_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mtx_d   = mtx_row;
          vec_d   = vec;
          sl_d    = shift_left;
          col_d   = '0;
          grp_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_col) begin
          col_d = '0;
          if (grp_q == GRP_LAST) begin
            grp_d   = '0;
            state_d = ST_DONE;
          end else begin
            grp_d = grp_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (result_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      grp_q   <= '0;
      sl_q    <= 1'b0;
      for (int i = 0; i < MTX_SIZE; i++) begin
        mtx_q[i] <= '0;
        vec_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      grp_q   <= grp_d;
      sl_q    <= sl_d;
      mtx_q   <= mtx_d;
      vec_q   <= vec_d;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    int unsigned           row;
    int unsigned           idx;
    logic [WORD_WIDTH-1:0] coef;
    logic [WORD_WIDTH-1:0] acc_d, acc_q;

    // Circulant index: (col + row) mod N for left shift, (col - row) mod N otherwise.
    always_comb begin
      row = 32'(grp_q) * LANES + 32'(gi);
      idx = sl_q ? (32'(col_q) + row) : (32'(col_q) + MTX_SIZE - row);
      if (idx >= MTX_SIZE) idx = idx - MTX_SIZE;
      coef = mtx_q[CW'(idx)];
    end

    m31_mac #(.WORD_WIDTH(WORD_WIDTH)) u_mac (
      .acc (acc_q),
      .a   (coef),
      .b   (vec_q[col_q]),
      .sum (mac_sum[gi])
    );

    always_comb begin
      acc_d = acc_q;
      if (accept)   acc_d = '0;
      else if (run) acc_d = last_col ? '0 : mac_sum[gi];
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) acc_q <= '0;
      else        acc_q <= acc_d;
    end
  end

  // Each result word is owned by one (group, lane) pair and loads when that group closes.
  for (genvar gi = 0; gi < MTX_SIZE; gi++) begin : g_res
    localparam int unsigned   LANE = gi % LANES;
    localparam logic [GW-1:0] GRP  = GW'(gi / LANES);
    logic [WORD_WIDTH-1:0] word_d, word_q;

    always_comb begin
      word_d = word_q;
      if (run && last_col && (grp_q == GRP)) word_d = mac_sum[LANE];
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) word_q <= '0;
      else        word_q <= word_d;
    end

    assign result[gi] = word_q;
  end

endmodule

// File: tb/tb_circ_mtx_vec_mul_seq.sv
// Self-checking bench: three instances (LANES = 1, 4, 16) driven with directed
// and random operands, checked against a plain-arithmetic circulant product.
module tb_circ_mtx_vec_mul_seq;

  localparam int W  = 31;
  localparam int N  = 16;
  localparam int ND = 3;
  localparam longint unsigned P = 64'h7FFF_FFFF;

  logic clk = 1'b0;
  logic reset;
  logic [W-1:0] mtx_s [ND][N];
  logic [W-1:0] vec_s [ND][N];
  logic [W-1:0] res_s [ND][N];
  logic sl_s [ND];
  logic iv_s [ND];
  logic ir_s [ND];
  logic rv_s [ND];
  logic rr_s [ND];
  logic busy_s [ND];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic int lanes_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 4 : 16);
  endfunction

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    circ_mtx_vec_mul_seq #(
      .WORD_WIDTH (W),
      .MTX_SIZE   (N),
      .LANES      ((gi == 0) ? 1 : ((gi == 1) ? 4 : 16))
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .mtx_row      (mtx_s[gi]),
      .vec          (vec_s[gi]),
      .shift_left   (sl_s[gi]),
      .in_valid     (iv_s[gi]),
      .in_ready     (ir_s[gi]),
      .result       (res_s[gi]),
      .result_valid (rv_s[gi]),
      .result_ready (rr_s[gi]),
      .busy         (busy_s[gi])
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Row r, column j of C is mtx[(j - r) mod N] (right) or mtx[(j + r) mod N] (left).
  function automatic void model(input logic [W-1:0] m [N], input logic [W-1:0] v [N],
                                input logic sl, output logic [W-1:0] r [N]);
    longint unsigned acc;
    int k;
    for (int row = 0; row < N; row++) begin
      acc = 0;
      for (int j = 0; j < N; j++) begin
        k = sl ? ((j + row) % N) : ((j - row + N) % N);
        acc = (acc + (longint'(m[k]) % P) * (longint'(v[j]) % P)) % P;
      end
      r[row] = W'(acc);
    end
  endfunction

  task automatic start_op(input int d, input logic [W-1:0] m [N], input logic [W-1:0] v [N],
                          input logic sl);
    int wt;
    @(negedge clk);
    mtx_s[d] = m;
    vec_s[d] = v;
    sl_s[d]  = sl;
    iv_s[d]  = 1'b1;
    wt = 0;
    while (!ir_s[d] && wt < 100) begin
      @(negedge clk);
      wt++;
    end
    check($sformatf("dut%0d in_ready before accept", d), 64'(ir_s[d]), 64'd1);
    @(posedge clk);
    #1;
    iv_s[d] = 1'b0;
    // Scramble the ports: the captured copy must be the one used.
    for (int i = 0; i < N; i++) begin
      mtx_s[d][i] = W'($urandom);
      vec_s[d][i] = W'($urandom);
    end
    sl_s[d] = ~sl;
    check($sformatf("dut%0d busy after accept", d), 64'(busy_s[d]), 64'd1);
  endtask

  task automatic finish_op(input int d, input string tag, input logic [W-1:0] exp [N],
                           input int hold, output logic [W-1:0] got [N]);
    int lat;
    lat = 0;
    while (!rv_s[d] && lat < 1000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("dut%0d %s latency", d, tag), 64'(lat), 64'(N * N / lanes_of(d)));
    for (int i = 0; i < N; i++)
      check($sformatf("dut%0d %s result[%0d]", d, tag, i), 64'(res_s[d][i]), 64'(exp[i]));
    got = res_s[d];
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check($sformatf("dut%0d %s hold valid", d, tag), 64'(rv_s[d]), 64'd1);
      check($sformatf("dut%0d %s hold in_ready", d, tag), 64'(ir_s[d]), 64'd0);
      for (int i = 0; i < N; i++)
        check($sformatf("dut%0d %s hold result[%0d]", d, tag, i), 64'(res_s[d][i]), 64'(exp[i]));
    end
    rr_s[d] = 1'b1;
    @(posedge clk);
    #1;
    rr_s[d] = 1'b0;
    check($sformatf("dut%0d %s valid after take", d, tag), 64'(rv_s[d]), 64'd0);
    check($sformatf("dut%0d %s in_ready after take", d, tag), 64'(ir_s[d]), 64'd1);
    $display("op dut%0d lanes=%0d %s sl=%0b lat=%0d res0=0x%0h", d, lanes_of(d), tag,
             sl_s[d] ^ 1'b1, lat, got[0]);
  endtask

  task automatic run_op(input int d, input string tag, input logic [W-1:0] m [N],
                        input logic [W-1:0] v [N], input logic sl, input int hold,
                        output logic [W-1:0] got [N]);
    logic [W-1:0] exp [N];
    model(m, v, sl, exp);
    start_op(d, m, v, sl);
    finish_op(d, tag, exp, hold, got);
  endtask

  task automatic sweep(input int d);
    logic [W-1:0] m [N];
    logic [W-1:0] v [N];
    logic [W-1:0] got [N];
    for (int t = 0; t < 200; t++) begin
      for (int i = 0; i < N; i++) begin
        m[i] = W'($urandom_range(32'h7FFF_FFFE, 0));
        v[i] = W'($urandom_range(32'h7FFF_FFFE, 0));
      end
      run_op(d, "rand", m, v, 1'($urandom_range(1, 0)), int'($urandom_range(2, 0)), got);
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("dut%0d %s in_ready", d, tag), 64'(ir_s[d]), 64'd1);
      check($sformatf("dut%0d %s result_valid", d, tag), 64'(rv_s[d]), 64'd0);
      check($sformatf("dut%0d %s busy", d, tag), 64'(busy_s[d]), 64'd0);
      for (int i = 0; i < N; i++)
        check($sformatf("dut%0d %s result[%0d]", d, tag, i), 64'(res_s[d][i]), 64'd0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] m [N];
    logic [W-1:0] v [N];
    logic [W-1:0] got [N];

    reset = 1'b0;
    for (int d = 0; d < ND; d++) begin
      sl_s[d] = 1'b0;
      iv_s[d] = 1'b0;
      rr_s[d] = 1'b0;
      for (int i = 0; i < N; i++) begin
        mtx_s[d][i] = '0;
        vec_s[d][i] = '0;
      end
    end
    #1;
    check_reset_state("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_state("post-reset");

    // Identity.
    for (int i = 0; i < N; i++) begin
      m[i] = '0;
      v[i] = W'(i);
    end
    m[0] = W'(1);
    run_op(1, "identity", m, v, 1'b0, 0, got);
    for (int i = 0; i < N; i++) check($sformatf("identity const[%0d]", i), 64'(got[i]), 64'(i));

    // Shift direction.
    for (int i = 0; i < N; i++) begin
      m[i] = '0;
      v[i] = W'(100 + i);
    end
    m[1] = W'(1);
    run_op(1, "shift_right", m, v, 1'b0, 0, got);
    check("shift_right const[0]", 64'(got[0]), 64'd101);
    check("shift_right const[15]", 64'(got[15]), 64'd100);
    run_op(1, "shift_left", m, v, 1'b1, 0, got);
    check("shift_left const[2]", 64'(got[2]), 64'd115);
    check("shift_left const[0]", 64'(got[0]), 64'd101);

    // Modular wrap.
    for (int i = 0; i < N; i++) begin
      m[i] = W'(32'h7FFF_FFFE);
      v[i] = W'(32'h7FFF_FFFE);
    end
    run_op(1, "wrap_pm1", m, v, 1'b0, 0, got);
    for (int i = 0; i < N; i++) check($sformatf("wrap_pm1 const[%0d]", i), 64'(got[i]), 64'd16);
    for (int i = 0; i < N; i++) begin
      m[i] = '0;
      v[i] = W'(2);
    end
    m[0] = W'(32'h4000_0000);
    run_op(1, "wrap_2p30", m, v, 1'b1, 0, got);
    for (int i = 0; i < N; i++) check($sformatf("wrap_2p30 const[%0d]", i), 64'(got[i]), 64'd1);

    // Operands equal to p are congruent to zero.
    for (int i = 0; i < N; i++) begin
      m[i] = W'(32'h7FFF_FFFF);
      v[i] = W'($urandom);
    end
    run_op(1, "all_p", m, v, 1'b0, 0, got);
    check("all_p const[7]", 64'(got[7]), 64'd0);

    // Backpressure, then a back-to-back random operation.
    for (int i = 0; i < N; i++) begin
      m[i] = W'($urandom_range(32'h7FFF_FFFE, 0));
      v[i] = W'($urandom_range(32'h7FFF_FFFE, 0));
    end
    run_op(1, "backpressure", m, v, 1'b1, 10, got);
    for (int i = 0; i < N; i++) begin
      m[i] = W'($urandom_range(32'h7FFF_FFFE, 0));
      v[i] = W'($urandom_range(32'h7FFF_FFFE, 0));
    end
    run_op(1, "back_to_back", m, v, 1'b0, 0, got);

    // Reset mid-run.
    start_op(1, m, v, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_state("midrun-reset");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      m[i] = W'($urandom_range(32'h7FFF_FFFE, 0));
      v[i] = W'($urandom_range(32'h7FFF_FFFE, 0));
    end
    run_op(1, "after_reset", m, v, 1'b1, 0, got);

    // Random sweep across all three lane counts concurrently.
    fork
      sweep(0);
      sweep(1);
      sweep(2);
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
